// File: rtl/clk_seq_pkg.sv
// Shared constants for the clk_8f-domain clock sequencer: FSM state
// encoding and divider phase landmarks.
package clk_seq_pkg;

  localparam int PHASE_W = 3;

  // FSM state encoding (also driven out on the state port).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // Enabled edge at PH_RISE_F raises both clk_2f and clk_f.
  localparam logic [PHASE_W-1:0] PH_RISE_F  = 3'd0;
  // Enabled edge at PH_RISE_2F raises clk_2f only.
  localparam logic [PHASE_W-1:0] PH_RISE_2F = 3'd4;
  // Last phase of a clk_f frame; stopping here leaves the divider reset-equivalent.
  localparam logic [PHASE_W-1:0] PH_LAST    = 3'd7;

  // True when an enabled edge at this phase makes clk_2f rise.
  function automatic logic is_2f_rise(input logic [PHASE_W-1:0] ph);
    return (ph == PH_RISE_F) || (ph == PH_RISE_2F);
  endfunction

endpackage

// File: rtl/clk_phase_mirror.sv
// Mirror of the clk_8f divider phase. Produces one-cycle strobes that line
// up with the cycles in which clk_2f / clk_f have just gone high, and counts
// clk_f frames.
module clk_phase_mirror
  import clk_seq_pkg::*;
#(
  parameter int FCW = 8
) (
  input  logic               clk_8f,
  input  logic               rst,
  input  logic               gen_enb,
  input  logic               phase_clr,
  input  logic               frame_clr,
  output logic [PHASE_W-1:0] phase,
  output logic               stb_2f,
  output logic               stb_f,
  output logic [FCW-1:0]     frame_cnt
);

  logic [PHASE_W-1:0] phase_r;
  logic               stb_2f_r;
  logic               stb_f_r;
  logic [FCW-1:0]     frame_cnt_r;
  logic               rise_2f_s;
  logic               rise_f_s;

  // Decode which divider clocks rise on the current edge.
  always_comb begin
    rise_2f_s = gen_enb & is_2f_rise(phase_r);
    rise_f_s  = gen_enb & (phase_r == PH_RISE_F);
  end

  // Phase counter, strobe registers and frame counter.
  always_ff @(posedge clk_8f or negedge rst) begin
    if (!rst) begin
      phase_r     <= '0;
      stb_2f_r    <= 1'b0;
      stb_f_r     <= 1'b0;
      frame_cnt_r <= '0;
    end else begin
      if (phase_clr) begin
        phase_r <= '0;
      end else if (gen_enb) begin
        phase_r <= phase_r + PHASE_W'(1);
      end else begin
        phase_r <= phase_r;
      end
      stb_2f_r <= rise_2f_s;
      stb_f_r  <= rise_f_s;
      if (frame_clr) begin
        frame_cnt_r <= '0;
      end else if (rise_f_s) begin
        frame_cnt_r <= frame_cnt_r + FCW'(1);
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  assign phase     = phase_r;
  assign stb_2f    = stb_2f_r;
  assign stb_f     = stb_f_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: rtl/clk_seq_ctrl.sv
// Clock divider sequencer: start / warm-up / run / drain control of the
// clk_8f -> clk_2f/clk_f divider and the 2f/f datapath enable. Stopping
// only on frame boundaries leaves the divider in its reset-equivalent state.
module clk_seq_ctrl
  import clk_seq_pkg::*;
#(
  parameter int WARMUP_CYC   = 16,
  parameter int DRAIN_FRAMES = 2,
  parameter int FCW          = 8
) (
  input  logic           clk_8f,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  output logic           gen_rst,
  output logic           gen_enb,
  output logic           stb_2f,
  output logic           stb_f,
  output logic           dp_en,
  output logic           busy,
  output logic [FCW-1:0] frame_cnt,
  output logic [1:0]     state
);

  localparam int WCW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam int DCW = (DRAIN_FRAMES > 1) ? $clog2(DRAIN_FRAMES) : 1;
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(WARMUP_CYC - 1);
  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DRAIN_FRAMES - 1);

  logic [1:0]         state_r, state_s;
  logic               gen_rst_r, gen_rst_s;
  logic               gen_enb_r, gen_enb_s;
  logic               dp_en_r, dp_en_s;
  logic               busy_r, busy_s;
  logic [WCW-1:0]     wcnt_r, wcnt_s;
  logic [DCW-1:0]     dcnt_r, dcnt_s;
  logic               phase_clr_s;
  logic               frame_clr_s;
  logic [PHASE_W-1:0] phase_s;

  // Next-state and next-output decode for the sequencer FSM.
  always_comb begin
    state_s     = state_r;
    gen_rst_s   = gen_rst_r;
    gen_enb_s   = gen_enb_r;
    dp_en_s     = dp_en_r;
    wcnt_s      = wcnt_r;
    dcnt_s      = dcnt_r;
    phase_clr_s = 1'b0;
    frame_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        gen_enb_s = 1'b0;
        dp_en_s   = 1'b0;
        if (start && !stop) begin
          state_s     = ST_WARMUP;
          gen_rst_s   = 1'b0;
          wcnt_s      = '0;
          frame_clr_s = 1'b1;
        end else begin
          state_s   = ST_IDLE;
          gen_rst_s = 1'b1;
        end
      end
      ST_WARMUP: begin
        gen_enb_s = 1'b0;
        if (stop) begin
          state_s   = ST_IDLE;
          gen_rst_s = 1'b1;
        end else if (wcnt_r == WCNT_LAST) begin
          // Divider and datapath start together, from phase 0.
          state_s     = ST_RUN;
          gen_enb_s   = 1'b1;
          dp_en_s     = 1'b1;
          phase_clr_s = 1'b1;
        end else begin
          wcnt_s = wcnt_r + WCW'(1);
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Datapath stops at once; the divider runs on to a frame boundary.
          state_s = ST_DRAIN;
          dp_en_s = 1'b0;
          dcnt_s  = '0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (gen_enb_r && (phase_s == PH_LAST)) begin
          if (dcnt_r == DCNT_LAST) begin
            state_s   = ST_IDLE;
            gen_enb_s = 1'b0;
            gen_rst_s = 1'b1;
          end else begin
            dcnt_s = dcnt_r + DCW'(1);
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        gen_rst_s = 1'b1;
        gen_enb_s = 1'b0;
        dp_en_s   = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // Registered FSM state, counters and control outputs.
  always_ff @(posedge clk_8f or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      gen_rst_r <= 1'b1;
      gen_enb_r <= 1'b0;
      dp_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      wcnt_r    <= '0;
      dcnt_r    <= '0;
    end else begin
      state_r   <= state_s;
      gen_rst_r <= gen_rst_s;
      gen_enb_r <= gen_enb_s;
      dp_en_r   <= dp_en_s;
      busy_r    <= busy_s;
      wcnt_r    <= wcnt_s;
      dcnt_r    <= dcnt_s;
    end
  end

  clk_phase_mirror #(
    .FCW(FCW)
  ) u_mirror (
    .clk_8f    (clk_8f),
    .rst       (rst),
    .gen_enb   (gen_enb_r),
    .phase_clr (phase_clr_s),
    .frame_clr (frame_clr_s),
    .phase     (phase_s),
    .stb_2f    (stb_2f),
    .stb_f     (stb_f),
    .frame_cnt (frame_cnt)
  );

  assign gen_rst = gen_rst_r;
  assign gen_enb = gen_enb_r;
  assign dp_en   = dp_en_r;
  assign busy    = busy_r;
  assign state   = state_r;

endmodule

// File: tb/tb_clk_seq_ctrl.sv
// Scoreboard bench for clk_seq_ctrl. Each start/stop episode is summarised
// arithmetically (busy length, enabled edges, strobe counts) and queued; a
// monitor measures the same quantities on the DUT and compares when busy
// drops. A behavioural divider driven by gen_rst/gen_enb is checked against
// the strobes every cycle.
module tb_clk_seq_ctrl;

  localparam int WC  = 4;
  localparam int DF  = 2;
  localparam int FCW = 8;

  logic           clk_8f = 1'b0;
  logic           rst    = 1'b0;
  logic           start  = 1'b0;
  logic           stop   = 1'b0;
  logic           gen_rst, gen_enb, stb_2f, stb_f, dp_en, busy;
  logic [FCW-1:0] frame_cnt;
  logic [1:0]     state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int busy_cyc;
    int enb_cyc;
    int dp_cyc;
    int nf;
    int n2f;
    int fc;
    int first_enb;
    int first_f;
  } ep_t;

  ep_t sb_q[$];

  clk_seq_ctrl #(
    .WARMUP_CYC   (WC),
    .DRAIN_FRAMES (DF),
    .FCW          (FCW)
  ) dut (
    .clk_8f    (clk_8f),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .gen_rst   (gen_rst),
    .gen_enb   (gen_enb),
    .stb_2f    (stb_2f),
    .stb_f     (stb_f),
    .dp_en     (dp_en),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .state     (state)
  );

  always #5 clk_8f = ~clk_8f;

  // Behavioural divider: clk_2f = clk_8f/4, clk_f = clk_8f/8.
  logic [2:0] div_cnt = 3'd0;
  logic       div_2f  = 1'b0;
  logic       div_f   = 1'b0;
  always @(posedge clk_8f) begin
    if (gen_rst === 1'b1) begin
      div_cnt <= 3'd0;
      div_2f  <= 1'b0;
      div_f   <= 1'b0;
    end else if (gen_enb === 1'b1) begin
      div_cnt <= div_cnt + 3'd1;
      case (div_cnt)
        3'd0: begin div_2f <= 1'b1; div_f <= 1'b1; end
        3'd2: div_2f <= 1'b0;
        3'd4: begin div_2f <= 1'b1; div_f <= 1'b0; end
        3'd6: div_2f <= 1'b0;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Full run episode stopped after k enabled RUN edges: the divider halts at
  // the end of the frame in progress plus DF-1 further frames.
  function automatic ep_t model_run(input int k);
    ep_t e;
    int  n;
    n           = 8 * (k / 8 + DF);
    e.busy_cyc  = WC + n;
    e.enb_cyc   = n;
    e.dp_cyc    = k;
    e.nf        = n / 8;
    e.n2f       = n / 4;
    e.fc        = (n / 8) % (1 << FCW);
    e.first_enb = WC;
    e.first_f   = WC + 1;
    return e;
  endfunction

  // Warm-up aborted by stop on the j-th edge after leaving IDLE.
  function automatic ep_t model_abort(input int j);
    ep_t e;
    e.busy_cyc  = j;
    e.enb_cyc   = 0;
    e.dp_cyc    = 0;
    e.nf        = 0;
    e.n2f       = 0;
    e.fc        = 0;
    e.first_enb = -1;
    e.first_f   = -1;
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},     32'(state),     32'd0);
    check({tag, "_gen_rst"},   32'(gen_rst),   32'd1);
    check({tag, "_gen_enb"},   32'(gen_enb),   32'd0);
    check({tag, "_stb_2f"},    32'(stb_2f),    32'd0);
    check({tag, "_stb_f"},     32'(stb_f),     32'd0);
    check({tag, "_dp_en"},     32'(dp_en),     32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  task automatic drive(input logic s, input logic p);
    start = s;
    stop  = p;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 6000) begin
      drive(1'b0, 1'($urandom % 2));
      n++;
    end
    check("drain_bound", 32'(n < 6000), 32'd1);
    stop = 1'b0;
  endtask

  task automatic run_ep(input int k);
    sb_q.push_back(model_run(k));
    drive(1'b1, 1'b0);
    repeat (WC) drive(1'($urandom % 2), 1'b0);
    repeat (k - 1) drive(1'($urandom % 2), 1'b0);
    drive(1'($urandom % 2), 1'b1);
    wait_idle();
    drive(1'b0, 1'b0);
  endtask

  task automatic abort_ep(input int j);
    sb_q.push_back(model_abort(j));
    drive(1'b1, 1'b0);
    repeat (j - 1) drive(1'($urandom % 2), 1'b0);
    drive(1'($urandom % 2), 1'b1);
    drive(1'b0, 1'b0);
  endtask

  // Monitor: per-cycle divider/strobe consistency, episode measurement and
  // scoreboard comparison when busy falls.
  logic busy_prev = 1'b0;
  logic p2f = 1'b0;
  logic pf  = 1'b0;
  int   busy_cyc, enb_cyc, dp_cyc, nf, n2f, first_enb, first_f;
  initial begin
    busy_cyc = 0; enb_cyc = 0; dp_cyc = 0; nf = 0; n2f = 0;
    first_enb = -1; first_f = -1;
  end

  always @(negedge clk_8f) begin
    if (rst !== 1'b1) begin
      busy_prev = 1'b0;
      nf        = 0;
      p2f       = div_2f;
      pf        = div_f;
    end else begin
      check("stb_2f_vs_div", 32'(stb_2f), 32'(div_2f & ~p2f));
      check("stb_f_vs_div",  32'(stb_f),  32'(div_f & ~pf));
      p2f = div_2f;
      pf  = div_f;
      if (busy === 1'b1 && busy_prev === 1'b0) begin
        busy_cyc = 0; enb_cyc = 0; dp_cyc = 0; nf = 0; n2f = 0;
        first_enb = -1; first_f = -1;
      end
      if (busy === 1'b1) begin
        if (gen_enb === 1'b1 && first_enb < 0) first_enb = busy_cyc;
        if (stb_f === 1'b1 && first_f < 0) first_f = busy_cyc;
        enb_cyc  += int'(gen_enb);
        dp_cyc   += int'(dp_en);
        busy_cyc += 1;
      end
      nf  += int'(stb_f);
      n2f += int'(stb_2f);
      check("frame_cnt_track", 32'(frame_cnt), 32'(nf % (1 << FCW)));
      if (busy === 1'b0 && busy_prev === 1'b1) begin
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_episode: got busy_cyc %0d expected no episode", busy_cyc);
        end else begin
          ep_t e;
          e = sb_q.pop_front();
          check("ep_busy_cyc",  32'(busy_cyc),  32'(e.busy_cyc));
          check("ep_enb_cyc",   32'(enb_cyc),   32'(e.enb_cyc));
          check("ep_dp_cyc",    32'(dp_cyc),    32'(e.dp_cyc));
          check("ep_nf",        32'(nf),        32'(e.nf));
          check("ep_n2f",       32'(n2f),       32'(e.n2f));
          check("ep_frame_cnt", 32'(frame_cnt), 32'(e.fc));
          check("ep_first_enb", 32'(first_enb), 32'(e.first_enb));
          check("ep_first_f",   32'(first_f),   32'(e.first_f));
          check("ep_end_state", 32'(state),     32'd0);
          check("ep_end_gen_rst", 32'(gen_rst), 32'd1);
          check("ep_div_cnt",   32'(div_cnt),   32'd0);
          check("ep_div_2f",    32'(div_2f),    32'd0);
          check("ep_div_f",     32'(div_f),     32'd0);
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk_8f);
    #1;
    check_reset_vals("por");
    rst = 1'b1;
    repeat (2) drive(1'b0, 1'b0);

    // Stop at phase 3, then a 64-cycle run.
    run_ep(4);
    run_ep(64);

    // start and stop together in IDLE: stop wins.
    repeat (3) begin
      drive(1'b1, 1'b1);
      check("both_busy",  32'(busy),  32'd0);
      check("both_state", 32'(state), 32'd0);
    end
    drive(1'b0, 1'b0);

    // Warm-up aborts: at wcnt=2, and on the edge that would enter RUN.
    abort_ep(3);
    abort_ep(WC);

    // Randomised mix of episodes.
    for (int i = 0; i < 8; i++) begin
      if ($urandom % 3 == 0) abort_ep($urandom_range(1, WC));
      else run_ep($urandom_range(1, 40));
    end

    // Asynchronous reset between edges in the middle of RUN.
    drive(1'b1, 1'b0);
    repeat (WC + 5) drive(1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("mid_run_rst");
    @(posedge clk_8f);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0);
    run_ep(13);

    // Long run: frame_cnt wraps past 255.
    run_ep(8 * 258 + 3);

    repeat (3) drive(1'b0, 1'b0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
